// File: rtl/mux_n_skid_pkg.sv
// Shared types and helpers for the mux_n_skid selector slice.
package mux_n_pkg;

    typedef enum logic [1:0] {SK_EMPTY, SK_ONE, SK_TWO} skid_state_e;

    // Fill bit for the out-of-range default word; replicate to the word width.
    localparam logic DEFAULT_FILL = 1'b1;

    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/mux_n_skid_if.sv
// Request/response bundle for mux_n_skid: select side and back-pressured word side.
interface mux_n_skid_if #(
    parameter int NUM_CH = 9,
    parameter int WIDTH  = 16,
    parameter int SEL_W  = 4
);
    logic [NUM_CH*WIDTH-1:0] din;
    logic [SEL_W-1:0]        sel;
    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH-1:0]        dout;
    logic                    sel_err;
    logic                    out_valid;
    logic                    out_ready;

    modport master (
        output din, sel, in_valid, out_ready,
        input  in_ready, dout, sel_err, out_valid
    );

    modport slave (
        input  din, sel, in_valid, out_ready,
        output in_ready, dout, sel_err, out_valid
    );
endinterface

// File: rtl/mux_n_skid_buf.sv
// Generic 2-entry skid buffer; in_ready is registered and only reflects skid occupancy.
module mux_n_skid_buf
    import mux_n_pkg::*;
#(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    skid_state_e  state_q, state_d;
    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         rdy_q;
    logic         accept;
    logic         transfer;

    assign in_ready  = rdy_q;
    assign out_valid = (state_q != SK_EMPTY);
    assign out_data  = main_q;
    assign accept    = in_valid & rdy_q;
    assign transfer  = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            SK_EMPTY: begin
                if (accept) begin
                    main_d  = in_data;
                    state_d = SK_ONE;
                end
            end
            SK_ONE: begin
                if (accept && transfer) begin
                    main_d = in_data;
                end else if (accept) begin
                    skid_d  = in_data;
                    state_d = SK_TWO;
                end else if (transfer) begin
                    state_d = SK_EMPTY;
                end
            end
            SK_TWO: begin
                if (transfer) begin
                    main_d  = skid_q;
                    state_d = SK_ONE;
                end
            end
            default: state_d = SK_EMPTY;
        endcase
    end

    // rdy_q tracks the next state so it is low exactly while both entries are full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SK_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            rdy_q   <= (state_d != SK_TWO);
        end
    end

endmodule

// File: rtl/mux_n_skid.sv
// N-to-1 word selector with out-of-range default and registered skid output.
// Optional saturating error counter enabled by MUX_N_SKID_ERR_CNT_EN.
module mux_n_skid
    import mux_n_pkg::*;
#(
    parameter int               NUM_CH       = 9,
    parameter int               WIDTH        = 16,
    parameter int               SEL_W        = clog2_min1(NUM_CH),
    parameter logic [WIDTH-1:0] DEFAULT_WORD = {WIDTH{DEFAULT_FILL}}
) (
    input  logic        clk,
    input  logic        rst_n,
    mux_n_skid_if.slave bus
`ifdef MUX_N_SKID_ERR_CNT_EN
    ,
    output logic [15:0] err_cnt
`endif
);

    logic [WIDTH-1:0] word;
    logic             err;
    logic [WIDTH:0]   out_word;

    always_comb begin
        word = DEFAULT_WORD;
        err  = 1'b1;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (bus.sel == SEL_W'(k)) begin
                word = bus.din[k*WIDTH +: WIDTH];
                err  = 1'b0;
            end
        end
    end

    mux_n_skid_buf #(
        .W(WIDTH + 1)
    ) u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  ({err, word}),
        .in_valid (bus.in_valid),
        .in_ready (bus.in_ready),
        .out_data (out_word),
        .out_valid(bus.out_valid),
        .out_ready(bus.out_ready)
    );

    assign bus.dout    = out_word[WIDTH-1:0];
    assign bus.sel_err = out_word[WIDTH];

`ifdef MUX_N_SKID_ERR_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (bus.in_valid && bus.in_ready && err && (err_cnt != 16'hFFFF)) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mux_n_skid.sv
// Randomized and directed checks of mux_n_skid against a queue-based reference model.
module tb_mux_n_skid;

    localparam int NUM_CH = 9;
    localparam int WIDTH  = 16;
    localparam int SEL_W  = 4;

    typedef struct packed {
        logic             err;
        logic [WIDTH-1:0] word;
    } item_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    mux_n_skid_if #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .SEL_W(SEL_W)) bus ();

`ifdef MUX_N_SKID_ERR_CNT_EN
    logic [15:0] err_cnt;
`endif

    mux_n_skid #(
        .NUM_CH      (NUM_CH),
        .WIDTH       (WIDTH),
        .SEL_W       (SEL_W),
        .DEFAULT_WORD(16'hFFFF)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
`ifdef MUX_N_SKID_ERR_CNT_EN
        ,
        .err_cnt(err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    item_t       q[$];
    bit          armed    = 1'b0;
    int unsigned errc     = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic item_t ref_select(input logic [SEL_W-1:0] s, input logic [NUM_CH*WIDTH-1:0] d);
        item_t it;
        int idx;
        idx = int'(s);
        if (idx < NUM_CH) begin
            it.err  = 1'b0;
            it.word = d[idx*WIDTH +: WIDTH];
        end else begin
            it.err  = 1'b1;
            it.word = 16'hFFFF;
        end
        return it;
    endfunction

    task automatic check_outputs();
        if (!armed) begin
            check_eq("idle_in_ready", 32'(bus.in_ready), 32'd0);
            check_eq("idle_out_valid", 32'(bus.out_valid), 32'd0);
            check_eq("idle_dout", 32'(bus.dout), 32'd0);
            check_eq("idle_sel_err", 32'(bus.sel_err), 32'd0);
        end else begin
            check_eq("in_ready", 32'(bus.in_ready), 32'(q.size() < 2));
            check_eq("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
            if (q.size() > 0) begin
                check_eq("dout", 32'(bus.dout), 32'(q[0].word));
                check_eq("sel_err", 32'(bus.sel_err), 32'(q[0].err));
            end
        end
`ifdef MUX_N_SKID_ERR_CNT_EN
        check_eq("err_cnt", 32'(err_cnt), errc);
`endif
    endtask

    // Called at a negedge: check, drive, then advance the model on the posedge.
    task automatic cycle(input bit iv, input logic [SEL_W-1:0] s, input bit ordy, output bit acc);
        bit tr;
        check_outputs();
        bus.in_valid  = iv;
        bus.sel       = s;
        bus.out_ready = ordy;
        @(posedge clk);
        acc = 1'b0;
        if (rst_n) begin
            tr  = (q.size() > 0) && ordy;
            acc = armed && iv && (q.size() < 2);
            if (tr) void'(q.pop_front());
            if (acc) begin
                q.push_back(ref_select(s, bus.din));
                if ((int'(s) >= NUM_CH) && (errc < 32'hFFFF)) errc++;
            end
            armed = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic load_din();
        for (int k = 0; k < NUM_CH; k++) bus.din[k*WIDTH +: WIDTH] = 16'h1000 + 16'(k);
    endtask

    initial begin
        bit               acc;
        bit               pend;
        bit               iv;
        logic [SEL_W-1:0] ps;

        load_din();
        bus.in_valid  = 1'b0;
        bus.sel       = '0;
        bus.out_ready = 1'b0;

        repeat (3) begin
            @(negedge clk);
            check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
            check_eq("rst_in_ready", 32'(bus.in_ready), 32'd0);
            check_eq("rst_dout", 32'(bus.dout), 32'd0);
            check_eq("rst_sel_err", 32'(bus.sel_err), 32'd0);
`ifdef MUX_N_SKID_ERR_CNT_EN
            check_eq("rst_err_cnt", 32'(err_cnt), 32'd0);
`endif
        end
        rst_n = 1'b1;
        cycle(1'b0, '0, 1'b0, acc);

        // Full select sweep, back-to-back.
        for (int s = 0; s < 16; s++) cycle(1'b1, SEL_W'(s), 1'b1, acc);
        repeat (2) cycle(1'b0, '0, 1'b1, acc);

        // Back-pressure: fill both entries, hold the third request, then drain.
        cycle(1'b1, 4'd2, 1'b0, acc);
        cycle(1'b1, 4'd3, 1'b0, acc);
        cycle(1'b1, 4'd4, 1'b0, acc);
        cycle(1'b1, 4'd4, 1'b0, acc);
        cycle(1'b1, 4'd4, 1'b1, acc);
        cycle(1'b1, 4'd4, 1'b1, acc);
        repeat (3) cycle(1'b0, '0, 1'b1, acc);

        // Simultaneous accept and transfer.
        for (int i = 0; i < 20; i++) cycle(1'b1, (i % 2 == 1) ? 4'd5 : 4'd1, 1'b1, acc);
        repeat (2) cycle(1'b0, '0, 1'b1, acc);

        // Asynchronous reset while both entries are full.
        cycle(1'b1, 4'd2, 1'b0, acc);
        cycle(1'b1, 4'd3, 1'b0, acc);
        check_outputs();
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("async_in_ready", 32'(bus.in_ready), 32'd0);
`ifdef MUX_N_SKID_ERR_CNT_EN
        check_eq("async_err_cnt", 32'(err_cnt), 32'd0);
`endif
        q.delete();
        armed = 1'b0;
        errc  = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b0, '0, 1'b1, acc);
        cycle(1'b1, 4'd7, 1'b1, acc);
        repeat (2) cycle(1'b0, '0, 1'b1, acc);

        // Randomized traffic with request hold until accepted.
        pend = 1'b0;
        iv   = 1'b0;
        ps   = '0;
        for (int i = 0; i < 3000; i++) begin
            if (!pend) begin
                iv = ($urandom_range(0, 3) != 0);
                ps = SEL_W'($urandom);
                if ($urandom_range(0, 7) == 0)
                    for (int k = 0; k < NUM_CH; k++) bus.din[k*WIDTH +: WIDTH] = 16'($urandom);
            end
            cycle(iv, ps, ($urandom_range(0, 3) != 0), acc);
            pend = iv && !acc;
        end
        while (pend) begin
            cycle(iv, ps, 1'b1, acc);
            pend = !acc;
        end
        repeat (3) cycle(1'b0, '0, 1'b1, acc);

`ifdef MUX_N_SKID_ERR_CNT_EN
        load_din();
        for (int i = 0; i < 70000; i++) cycle(1'b1, 4'd12, 1'b1, acc);
        repeat (3) cycle(1'b0, '0, 1'b1, acc);
        check_eq("err_cnt_sat", 32'(err_cnt), 32'h0000FFFF);
        rst_n = 1'b0;
        #1;
        check_eq("err_cnt_clr", 32'(err_cnt), 32'd0);
        q.delete();
        armed = 1'b0;
        errc  = 0;
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b0, '0, 1'b1, acc);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_n_skid.md
Name: mux_n_skid

Overview:
- Parametrised N-to-1 word selector. It is the next generation of the team's fixed 9-input, 16-bit combinational mux.
- Adds configurable channel count and width, a configurable default word for out-of-range selects, and a registered valid/ready output through a 2-entry skid buffer.
- Sits between parallel datapath sources and a single back-pressured consumer.

Parameters:
- NUM_CH, 9, number of input channels (2..64).
- WIDTH, 16, bits per channel word.
- SEL_W, 4, select width; must satisfy 2**SEL_W >= NUM_CH.
- DEFAULT_WORD, all ones of WIDTH, word emitted when sel >= NUM_CH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- din  input  NUM_CH*WIDTH  flattened channels; channel k occupies bits [k*WIDTH +: WIDTH].
- sel  input  SEL_W  channel select, sampled with in_valid.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- dout  output  WIDTH  selected word.
- sel_err  output  1  current dout came from an out-of-range sel.
- out_valid  output  1  dout/sel_err valid.
- out_ready  input  1  consumer accepts.
- err_cnt  output  16  saturating count of out-of-range requests; present only with macro.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- Values during reset:
  - out_valid=0, in_ready=0, dout=0, sel_err=0, err_cnt=0, both skid entries empty.
  - in_ready rises on the first clk edge after rst_n deasserts.
- Selection (combinational on the input side):
  - sel < NUM_CH: word = din[sel].
  - Otherwise: word = DEFAULT_WORD and err = 1.
- Handshake:
  - Input is accepted when in_valid & in_ready.
  - Output is transferred when out_valid & out_ready.
  - in_valid/sel/din must be held stable until accepted.
  - out_valid, once high, stays high with dout stable until transferred.
- Latency: an accepted request appears at dout/out_valid on the next clk edge (1 cycle).
- Throughput: 1 per cycle while out_ready=1.
- in_ready is a registered output, equal to "skid entry 1 empty". It never depends combinationally on out_ready.
- Skid states:
  - EMPTY: out_valid=0.
  - ONE: main register holds data, out_valid=1.
  - TWO: main register and skid register both hold data, in_ready=0.
- Transitions:
  - EMPTY + accept -> ONE.
  - ONE + accept & !transfer -> TWO.
  - ONE + transfer & !accept -> EMPTY.
  - ONE + accept & transfer -> ONE, with new data.
  - TWO + transfer -> ONE; the skid entry moves to the main register.
- Ordering: strict FIFO order; no request is dropped or duplicated.
- Reset mid-operation: all buffered data is discarded immediately (asynchronous); err_cnt is cleared.
- Boundaries:
  - sel = NUM_CH-1 is valid.
  - sel = NUM_CH and sel = 2**SEL_W-1 both give DEFAULT_WORD.
  - With NUM_CH = 2**SEL_W, err is never set.

Optional Feature:
- Macro: MUX_N_SKID_ERR_CNT_EN.
- When defined:
  - err_cnt port exists.
  - It increments by 1 on every accepted request with sel >= NUM_CH.
  - It saturates at 16'hFFFF.
  - It is cleared only by reset.
- When undefined:
  - err_cnt port and counter are absent.
  - sel_err is still produced.

Decomposition:
- Package mux_n_pkg:
  - function clog2_min1(n) for SEL_W derivation.
  - localparam-style default helper for an all-ones word.
  - typedef of skid state enum {SK_EMPTY, SK_ONE, SK_TWO}.
- Sub-module mux_n_skid_buf: generic WIDTH+1-bit (data plus err) 2-entry skid buffer with valid/ready on both sides.
- Top level holds the select decode and the optional counter.

Test Plan:
- Reset check: rst_n=0 for 3 cycles, then release → out_valid=0 and in_ready=0 during reset; in_ready=1 one cycle after release.
- Sweep NUM_CH=9, WIDTH=16, din[k]=16'h1000+k, out_ready=1; sel=0..15 back-to-back → out_valid every cycle, 1 cycle late.
  - dout=16'h1000..16'h1008 for sel 0..8.
  - dout=16'hFFFF with sel_err=1 for sel 9..15.
- Back-pressure: send sel=2,3,4 with out_ready=0 → after 2 accepts in_ready=0, and dout holds 16'h1002.
  - Then raise out_ready → outputs 16'h1002, 16'h1003, 16'h1004 in order; none lost.
- Simultaneous accept+transfer in ONE: alternate sel=1,5 continuously with out_ready=1 → in_ready stays 1; dout alternates 16'h1001/16'h1005.
- Mid-operation reset: assert rst_n=0 asynchronously between edges while in TWO → out_valid drops immediately; after release, the first output is the next new request only.
- With MUX_N_SKID_ERR_CNT_EN: 70000 requests with sel=12 → err_cnt=16'hFFFF and holds. Reset → err_cnt=0.
